tile_renderer: RTL and testbench

// - Pipelined tile-map pixel renderer for the snake VGA path. Maps the scan position to a map

---
 rtl/tile_renderer.sv | 155 +++++++++++++++
 tb/tb_tile_renderer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_renderer.sv
// Tile-map pixel renderer: scan position -> map RAM fetch -> procedural tile texture, 3 clk latency,
// 1 pixel/clk with no backpressure. Define FOOD_BLINK_EN to blink food tiles on a frame counter.
module tile_renderer #(
  parameter int TILE_LOG2  = 5,
  parameter int MAP_W      = 16,
  parameter int MAP_H      = 16,
  parameter int MAP_AW_X   = 4,
  parameter int MAP_AW_Y   = 4,
  parameter int CH_W       = 4,
  parameter int BLINK_LOG2 = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pix_valid_i,
  input  logic [9:0]                   pix_x_i,
  input  logic [9:0]                   pix_y_i,
  input  logic                         frame_start_i,
  output logic [MAP_AW_Y+MAP_AW_X-1:0] map_addr_o,
  input  logic [3:0]                   map_data_i,
  output logic                         pix_valid_o,
  output logic [3*CH_W-1:0]            pix_data_o,
  output logic                         out_of_map_o
);

  localparam logic [CH_W-1:0]   CMAX   = '1;
  localparam logic [CH_W-1:0]   CZERO  = '0;
  localparam logic [CH_W-1:0]   CMID   = {1'b1, {(CH_W-1){1'b0}}};
  localparam logic [3*CH_W-1:0] GREEN  = {CZERO, CMAX, CZERO};
  localparam logic [3*CH_W-1:0] BLUE   = {CMAX, CZERO, CZERO};
  localparam logic [3*CH_W-1:0] YELLOW = {CZERO, CMAX, CMAX};
  localparam logic [3*CH_W-1:0] PURPLE = {CMAX, CZERO, CMAX};
  localparam logic [3*CH_W-1:0] GREY   = {CMID, CMID, CMID};
  localparam logic [3*CH_W-1:0] BLACK  = '0;

  logic [9:0] col_full;
  logic [9:0] row_full;
  logic       oob_n;
  logic [4:0] u_n;
  logic [4:0] v_n;

  // Full-width indices so coordinates past the map are flagged rather than wrapped.
  assign col_full = pix_x_i >> TILE_LOG2;
  assign row_full = pix_y_i >> TILE_LOG2;
  assign oob_n    = (col_full >= 10'(MAP_W)) || (row_full >= 10'(MAP_H));
  assign u_n      = pix_x_i[4:0] << (5 - TILE_LOG2);
  assign v_n      = pix_y_i[4:0] << (5 - TILE_LOG2);

  logic       s0_vld, s0_oob, s1_vld, s1_oob;
  logic [4:0] s0_u, s0_v, s1_u, s1_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_vld     <= 1'b0;
      s0_oob     <= 1'b0;
      s0_u       <= '0;
      s0_v       <= '0;
      map_addr_o <= '0;
      s1_vld     <= 1'b0;
      s1_oob     <= 1'b0;
      s1_u       <= '0;
      s1_v       <= '0;
    end else begin
      s0_vld     <= pix_valid_i;
      s0_oob     <= oob_n;
      s0_u       <= u_n;
      s0_v       <= v_n;
      map_addr_o <= oob_n ? '0 : {row_full[MAP_AW_Y-1:0], col_full[MAP_AW_X-1:0]};
      s1_vld     <= s0_vld;
      s1_oob     <= s0_oob;
      s1_u       <= s0_u;
      s1_v       <= s0_v;
    end
  end

  logic food_on;

`ifdef FOOD_BLINK_EN
  logic [BLINK_LOG2:0] frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_cnt <= '0;
    else if (frame_start_i)
      frame_cnt <= frame_cnt + 1'b1;
  end

  assign food_on = ~frame_cnt[BLINK_LOG2];
`else
  logic unused_blink;
  assign unused_blink = frame_start_i ^ BLINK_LOG2[0];
  assign food_on      = 1'b1;
`endif

  logic                band_u, band_v, arm_h, arm_v, tail, in_eye, head_body;
  logic [4:0]          eye_u, eye_v;
  logic [3*CH_W-1:0]   colour;

  always_comb begin
    band_u    = (s1_u > 5'd8) && (s1_u < 5'd24);
    band_v    = (s1_v > 5'd8) && (s1_v < 5'd24);
    // Type bit0 picks left/right, bit1 picks up/down for corners and tails.
    arm_h     = band_v && (map_data_i[0] ? (s1_u > 5'd8) : (s1_u < 5'd24));
    arm_v     = band_u && (map_data_i[1] ? (s1_v > 5'd8) : (s1_v < 5'd24));
    tail      = map_data_i[1] ? (band_u && (s1_v[4] == map_data_i[0]))
                              : (band_v && (s1_u[4] == map_data_i[0]));
    eye_u     = 5'd16;
    eye_v     = 5'd16;
    case (map_data_i[1:0])
      2'd0:    eye_u = 5'd10;
      2'd1:    eye_u = 5'd22;
      2'd2:    eye_v = 5'd10;
      default: eye_v = 5'd22;
    endcase
    in_eye    = (s1_u >= eye_u) && (s1_u <= eye_u + 5'd3) &&
                (s1_v >= eye_v) && (s1_v <= eye_v + 5'd3);
    head_body = (s1_u > 5'd4) && (s1_u < 5'd28) && (s1_v > 5'd4) && (s1_v < 5'd28);
    colour    = GREEN;
    case (map_data_i[3:2])
      2'd0: begin
        case (map_data_i[1:0])
          2'd1:    if (band_u && band_v && food_on) colour = YELLOW;
          2'd2:    if (band_v) colour = BLUE;
          2'd3:    if (band_u) colour = BLUE;
          default: colour = GREEN;
        endcase
      end
      2'd1:    if (arm_h || arm_v) colour = BLUE;
      2'd2:    if (tail) colour = BLUE;
      default: begin
        if (in_eye)
          colour = BLACK;
        else if (head_body)
          colour = PURPLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid_o  <= 1'b0;
      pix_data_o   <= '0;
      out_of_map_o <= 1'b0;
    end else begin
      pix_valid_o  <= s1_vld;
      out_of_map_o <= s1_vld && s1_oob;
      if (!s1_vld)
        pix_data_o <= '0;
      else if (s1_oob)
        pix_data_o <= GREY;
      else
        pix_data_o <= colour;
    end
  end

endmodule

// File: tb/tb_tile_renderer.sv
// Bench for tile_renderer: two instances (32 px and 8 px tiles) against a geometric reference model.
module tb_tile_renderer;

  localparam logic [11:0] GREEN  = 12'h0F0;
  localparam logic [11:0] BLUE   = 12'hF00;
  localparam logic [11:0] YELLOW = 12'h0FF;
  localparam logic [11:0] PURPLE = 12'hF0F;
  localparam logic [11:0] GREY   = 12'h888;
  localparam logic [11:0] BLACK  = 12'h000;

  logic vgaclk = 1'b0;
  always #5 vgaclk = ~vgaclk;

  logic        rst, pv, fs;
  logic [9:0]  px, py;
  logic [7:0]  addr5, addr3;
  logic [3:0]  q5, q3;
  logic        v5o, v3o, o5, o3;
  logic [11:0] d5, d3;
  logic [3:0]  ram5 [0:255];
  logic [3:0]  ram3 [0:255];

  always @(posedge vgaclk) begin
    q5 <= ram5[addr5];
    q3 <= ram3[addr3];
  end

  tile_renderer dut5 (
    .clk(vgaclk), .rst(rst), .pix_valid_i(pv), .pix_x_i(px), .pix_y_i(py),
    .frame_start_i(fs), .map_addr_o(addr5), .map_data_i(q5),
    .pix_valid_o(v5o), .pix_data_o(d5), .out_of_map_o(o5)
  );

  tile_renderer #(.TILE_LOG2(3), .MAP_W(12), .MAP_H(10), .BLINK_LOG2(1)) dut3 (
    .clk(vgaclk), .rst(rst), .pix_valid_i(pv), .pix_x_i(px), .pix_y_i(py),
    .frame_start_i(fs), .map_addr_o(addr3), .map_data_i(q3),
    .pix_valid_o(v3o), .pix_data_o(d3), .out_of_map_o(o3)
  );

  typedef struct packed {
    logic        v5;
    logic        o5;
    logic [11:0] d5;
    logic        v3;
    logic        o3;
    logic [11:0] d3;
  } exp_t;

  exp_t q[$];
  int vectors     = 0;
  int miscompares = 0;
  int fr          = 0;

  function automatic bit is_oob(int tl, int mw, int mh, int x, int y);
    return ((x / (1 << tl)) >= mw) || ((y / (1 << tl)) >= mh);
  endfunction

  function automatic int map_index(int tl, int mw, int mh, int x, int y);
    if (is_oob(tl, mw, mh, x, y)) return 0;
    return (y / (1 << tl)) * 16 + (x / (1 << tl));
  endfunction

  function automatic logic [11:0] tex(int t, int u, int v, bit dim);
    bit bu   = (u > 8) && (u < 24);
    bit bv   = (v > 8) && (v < 24);
    bit blue = 1'b0;
    int ex, ey;
    case (t)
      0:  return GREEN;
      1:  return (bu && bv && !dim) ? YELLOW : GREEN;
      2:  blue = bv;
      3:  blue = bu;
      4:  blue = (bv && u < 24) || (bu && v < 24);
      5:  blue = (bv && u > 8)  || (bu && v < 24);
      6:  blue = (bv && u < 24) || (bu && v > 8);
      7:  blue = (bv && u > 8)  || (bu && v > 8);
      8:  blue = bv && u < 16;
      9:  blue = bv && u >= 16;
      10: blue = bu && v < 16;
      11: blue = bu && v >= 16;
      default: begin
        ex = 16 + ((t == 12) ? -6 : (t == 13) ? 6 : 0);
        ey = 16 + ((t == 14) ? -6 : (t == 15) ? 6 : 0);
        if (u >= ex && u < ex + 4 && v >= ey && v < ey + 4) return BLACK;
        if (u > 4 && u < 28 && v > 4 && v < 28) return PURPLE;
        return GREEN;
      end
    endcase
    return blue ? BLUE : GREEN;
  endfunction

  // Returns {valid, out_of_map, colour}.
  function automatic logic [13:0] render(int tl, int mw, int mh, int bl, int t, bit v, int x, int y);
    int u   = (x % (1 << tl)) * (32 >> tl);
    int w   = (y % (1 << tl)) * (32 >> tl);
    bit dim = 1'b0;
`ifdef FOOD_BLINK_EN
    dim = ((fr >> bl) & 1) == 1;
`endif
    if (!v) return 14'd0;
    if (is_oob(tl, mw, mh, x, y)) return {2'b11, GREY};
    return {2'b10, tex(t, u, w, dim)};
  endfunction

  function automatic exp_t mk(bit v, int x, int y);
    logic [13:0] r5, r3;
    exp_t e;
    r5 = render(5, 16, 16, 4, int'(ram5[map_index(5, 16, 16, x, y)]), v, x, y);
    r3 = render(3, 12, 10, 1, int'(ram3[map_index(3, 12, 10, x, y)]), v, x, y);
    e.v5 = r5[13]; e.o5 = r5[12]; e.d5 = r5[11:0];
    e.v3 = r3[13]; e.o3 = r3[12]; e.d3 = r3[11:0];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string when);
    chk({when, "_vld5"}, 32'(v5o), 32'd0);
    chk({when, "_dat5"}, 32'(d5), 32'd0);
    chk({when, "_oob5"}, 32'(o5), 32'd0);
    chk({when, "_addr5"}, 32'(addr5), 32'd0);
    chk({when, "_vld3"}, 32'(v3o), 32'd0);
    chk({when, "_dat3"}, 32'(d3), 32'd0);
    chk({when, "_oob3"}, 32'(o3), 32'd0);
    chk({when, "_addr3"}, 32'(addr3), 32'd0);
  endtask

  // Empty pipeline: the next two outputs are bubbles.
  task automatic prime();
    q.delete();
    q.push_back('0);
    q.push_back('0);
  endtask

  task automatic tick(input bit v, input int x, input int y);
    exp_t e;
    pv = v;
    px = 10'(x);
    py = 10'(y);
    q.push_back(mk(v, x, y));
    @(posedge vgaclk);
    #1;
    chk("addr5", 32'(addr5), 32'(map_index(5, 16, 16, x, y)));
    chk("addr3", 32'(addr3), 32'(map_index(3, 12, 10, x, y)));
    if (q.size() >= 3) begin
      e = q.pop_front();
      chk("vld5", 32'(v5o), 32'(e.v5));
      chk("oob5", 32'(o5),  32'(e.o5));
      chk("dat5", 32'(d5),  32'(e.d5));
      chk("vld3", 32'(v3o), 32'(e.v3));
      chk("oob3", 32'(o3),  32'(e.o3));
      chk("dat3", 32'(d3),  32'(e.d3));
    end
  endtask

  task automatic flush();
    repeat (3) tick(1'b0, 0, 0);
  endtask

  task automatic pulse_frame();
    fs = 1'b1;
    tick(1'b0, 0, 0);
    fs = 1'b0;
    fr++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram5[i] = 4'd0;
      ram3[i] = 4'd0;
    end
    rst = 1'b1; pv = 1'b0; fs = 1'b0; px = '0; py = '0;
    repeat (3) @(posedge vgaclk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    prime();
    repeat (10) tick(1'b0, 0, 0);

    // Directed cells: food at {2,1}, vertical body for the 8 px instance at {0,1}.
    ram5[8'h21] = 4'd1;
    ram3[8'h01] = 4'd3;
    tick(1'b1, 40, 70);
    tick(1'b1, 48, 80);
    tick(1'b1, 13, 5);
    flush();

    // Tile boundary at x=32 with ground then horizontal body.
    ram5[8'h00] = 4'd0;
    ram5[8'h01] = 4'd2;
    for (int x = 0; x < 64; x++) tick(1'b1, x, 16);
    flush();

    // Out-of-map and last-cell edges.
    tick(1'b1, 520, 10);
    tick(1'b1, 100, 600);
    tick(1'b1, 1023, 1023);
    tick(1'b1, 95, 79);
    tick(1'b1, 96, 79);
    tick(1'b1, 95, 80);
    tick(1'b1, 511, 511);
    tick(1'b1, 512, 0);
    flush();

    // Random maps and random scan with bubbles.
    for (int i = 0; i < 256; i++) begin
      ram5[i] = 4'($urandom_range(0, 15));
      ram3[i] = 4'($urandom_range(0, 15));
    end
    for (int i = 0; i < 1500; i++)
      tick($urandom_range(0, 3) != 0, int'($urandom_range(0, 700)), int'($urandom_range(0, 560)));
    flush();

    // Food centre over eight frames.
    ram5[8'h11] = 4'd1;
    ram3[8'h66] = 4'd1;
    for (int f = 0; f < 8; f++) begin
      tick(1'b1, 52, 52);
      flush();
      pulse_frame();
    end

    // Asynchronous reset in mid-stream restarts the blink phase.
    pulse_frame();
    pulse_frame();
    tick(1'b1, 52, 52);
    tick(1'b1, 52, 52);
    tick(1'b1, 40, 70);
    rst = 1'b1;
    #2;
    chk_zero("midrst");
    rst = 1'b0;
    fr = 0;
    prime();
    tick(1'b1, 52, 52);
    tick(1'b1, 13, 5);
    flush();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
